// File: rtl/wb_port_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_port_arbiter_pkg : shared types for the writeback port arbiter    |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
package wb_port_arbiter_pkg;

  typedef enum logic [0:0] {
    NORMAL = 1'b0,
    DRAIN  = 1'b1
  } wb_arb_state_e;

  typedef struct packed {
    logic        we;
    logic [4:0]  waddr;
    logic [63:0] wdata;
  } rf_wr_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [63:0] data;
  } mdu_entry_t;

endpackage
`default_nettype wire

// File: rtl/wb_result_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_result_fifo : MDU result queue exposing per-slot valid and rd     |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module wb_result_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [4:0]               push_rd,
  input  logic [63:0]              push_data,
  input  logic                     pop,
  output logic [4:0]               head_rd,
  output logic [63:0]              head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic [DEPTH-1:0]         entry_valid,
  output logic [DEPTH*5-1:0]       entry_rd
);

  localparam int AW = $clog2(DEPTH);

  mdu_entry_t          mem [DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [AW:0]         count_q;
  logic [DEPTH-1:0]    valid_q;
  logic [DEPTH-1:0]    valid_next;

  // Slot validity is tracked explicitly so pending-rd decode needs no pointer math.
  always_comb begin
    valid_next = valid_q;
    if (pop)  valid_next[rd_ptr] = 1'b0;
    if (push) valid_next[wr_ptr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      valid_q <= valid_next;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{rd: push_rd, data: push_data};
  end

  assign head_rd     = mem[rd_ptr].rd;
  assign head_data   = mem[rd_ptr].data;
  assign count       = count_q;
  assign entry_valid = valid_q;

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry_rd
      assign entry_rd[i*5 +: 5] = mem[i].rd;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_port_arbiter : register-file write port shared by pipeline & MDU  |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pipe_valid,
  input  logic                     pipe_rd_en,
  input  logic [4:0]               pipe_rd,
  input  logic [63:0]              pipe_result,
  output logic                     pipe_stall,
  input  logic                     mdu_valid,
  output logic                     mdu_ready,
  input  logic [4:0]               mdu_rd,
  input  logic [63:0]              mdu_result,
  output logic                     rf_we,
  output logic [4:0]               rf_waddr,
  output logic [63:0]              rf_wdata,
  output logic [31:0]              mdu_pending,
  output logic [$clog2(DEPTH):0]   mdu_count
);

  localparam int                CW          = $clog2(DEPTH);
  localparam int                SW          = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW:0]       FULL_COUNT  = (CW+1)'(DEPTH);
  localparam logic [SW-1:0]     STARVE_LAST = SW'(STARVE_LIMIT - 1);

  wb_arb_state_e     state;
  logic [SW-1:0]     starve;
  rf_wr_t            rf;
  logic              rf_from_mdu;

  logic              pipe_req;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              starve_hit;
  logic [4:0]        head_rd;
  logic [63:0]       head_data;
  logic [DEPTH-1:0]  entry_valid;
  logic [DEPTH*5-1:0] entry_rd;

  assign pipe_stall = (state == DRAIN);
  assign pipe_req   = pipe_valid & pipe_rd_en & (pipe_rd != 5'd0) & ~pipe_stall;
  assign fifo_empty = (mdu_count == '0);
  assign mdu_ready  = (mdu_count != FULL_COUNT);
  // x0 results are handshaken but never stored.
  assign push       = mdu_valid & mdu_ready & (mdu_rd != 5'd0);
  assign pop        = ~fifo_empty & (pipe_stall | ~pipe_req);
  assign starve_hit = ~fifo_empty & ~pop & (starve == STARVE_LAST);

  wb_result_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .push_rd     (mdu_rd),
    .push_data   (mdu_result),
    .pop         (pop),
    .head_rd     (head_rd),
    .head_data   (head_data),
    .count       (mdu_count),
    .entry_valid (entry_valid),
    .entry_rd    (entry_rd)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= NORMAL;
      starve      <= '0;
      rf          <= '0;
      rf_from_mdu <= 1'b0;
    end else begin
      case (state)
        NORMAL:  if (starve_hit) state <= DRAIN;
        DRAIN:   state <= NORMAL;
        default: state <= NORMAL;
      endcase

      if (fifo_empty || pop) starve <= '0;
      else                   starve <= starve + 1'b1;

      rf.we       <= pipe_req | pop;
      rf_from_mdu <= pop;
      if (pipe_req) begin
        rf.waddr <= pipe_rd;
        rf.wdata <= pipe_result;
      end else if (pop) begin
        rf.waddr <= head_rd;
        rf.wdata <= head_data;
      end
    end
  end

  assign rf_we    = rf.we;
  assign rf_waddr = rf.waddr;
  assign rf_wdata = rf.wdata;

  // A register stays pending until its MDU write has actually landed.
  always_comb begin
    mdu_pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i]) mdu_pending[entry_rd[i*5 +: 5]] = 1'b1;
    end
    if (rf.we && rf_from_mdu) mdu_pending[rf.waddr] = 1'b1;
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_wb_port_arbiter : directed self-checking bench for wb_port_arbiter|
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_wb_port_arbiter;

  logic        clk;
  logic        rst;
  logic        pipe_valid;
  logic        pipe_rd_en;
  logic [4:0]  pipe_rd;
  logic [63:0] pipe_result;
  logic        pipe_stall;
  logic        mdu_valid;
  logic        mdu_ready;
  logic [4:0]  mdu_rd;
  logic [63:0] mdu_result;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic [31:0] mdu_pending;
  logic [2:0]  mdu_count;

  int errors = 0;
  int checks = 0;
  int q[$];
  int exp_rd;
  logic [4:0] c_rd [4];

  wb_port_arbiter #(.DEPTH(4), .STARVE_LIMIT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .pipe_valid  (pipe_valid),
    .pipe_rd_en  (pipe_rd_en),
    .pipe_rd     (pipe_rd),
    .pipe_result (pipe_result),
    .pipe_stall  (pipe_stall),
    .mdu_valid   (mdu_valid),
    .mdu_ready   (mdu_ready),
    .mdu_rd      (mdu_rd),
    .mdu_result  (mdu_result),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .mdu_pending (mdu_pending),
    .mdu_count   (mdu_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue-side hazard rule: the pipeline never writes a register with an MDU write outstanding.
  always @(negedge clk) begin
    if (rst && pipe_valid && pipe_rd_en && pipe_rd != 5'd0 && !pipe_stall)
      chk("hazard_pending", 64'(mdu_pending[pipe_rd]), 64'd0);
  end

  initial begin
    rst = 1'b0; pipe_valid = 0; pipe_rd_en = 0; pipe_rd = 0; pipe_result = 0;
    mdu_valid = 0; mdu_rd = 0; mdu_result = 0;
    c_rd = '{5'd2, 5'd3, 5'd4, 5'd6};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", mdu_count, 0);
    chk("rst_we", rf_we, 0);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_pending", mdu_pending, 0);
    chk("rst_stall", pipe_stall, 0);
    chk("rst_ready", mdu_ready, 1);
    rst = 1'b1;
    tick();

    // Idle drain
    mdu_valid = 1; mdu_rd = 5; mdu_result = 64'hAA; #1;
    chk("A_ready", mdu_ready, 1);
    chk("A_count0", mdu_count, 0);
    tick();
    mdu_valid = 0; #1;
    chk("A_count1", mdu_count, 1);
    chk("A_pend_q", mdu_pending[5], 1);
    chk("A_we_early", rf_we, 0);
    tick(); #1;
    chk("A_we", rf_we, 1);
    chk("A_waddr", rf_waddr, 5);
    chk("A_wdata", rf_wdata, 64'hAA);
    chk("A_count_pop", mdu_count, 0);
    chk("A_pend_wr", mdu_pending[5], 1);
    tick(); #1;
    chk("A_we_off", rf_we, 0);
    chk("A_pend_clr", mdu_pending, 0);
    chk("A_waddr_hold", rf_waddr, 5);

    // Starvation under continuous pipeline writes
    pipe_valid = 1; pipe_rd_en = 1; pipe_rd = 1; pipe_result = 64'h11;
    mdu_valid = 1; mdu_rd = 7; mdu_result = 64'h77; #1;
    chk("B_stall0", pipe_stall, 0);
    tick();
    mdu_valid = 0; #1;
    chk("B_count", mdu_count, 1);
    chk("B_pipe_we", rf_we, 1);
    chk("B_pipe_waddr", rf_waddr, 1);
    for (int i = 0; i < 4; i++) begin
      chk("B_wait_stall", pipe_stall, 0);
      tick(); #1;
    end
    chk("B_drain_stall", pipe_stall, 1);
    chk("B_drain_count", mdu_count, 1);
    tick(); #1;
    chk("B_resume_stall", pipe_stall, 0);
    chk("B_mdu_we", rf_we, 1);
    chk("B_mdu_waddr", rf_waddr, 7);
    chk("B_mdu_wdata", rf_wdata, 64'h77);
    chk("B_count_empty", mdu_count, 0);
    tick(); #1;
    chk("B_pipe_waddr2", rf_waddr, 1);
    chk("B_pipe_wdata2", rf_wdata, 64'h11);

    // Full FIFO, including the DRAIN pop cycle
    for (int i = 0; i < 4; i++) begin
      mdu_valid = 1; mdu_rd = c_rd[i]; mdu_result = 64'h20 + 64'(i); #1;
      chk("C_ready_fill", mdu_ready, 1);
      chk("C_count_fill", mdu_count, 64'(i));
      tick();
    end
    mdu_rd = 9; mdu_result = 64'h99; #1;
    chk("C_full_count", mdu_count, 4);
    chk("C_full_ready", mdu_ready, 0);
    chk("C_full_stall", pipe_stall, 0);
    tick(); #1;
    chk("C_drain_stall", pipe_stall, 1);
    chk("C_drain_ready", mdu_ready, 0);
    chk("C_drain_count", mdu_count, 4);
    tick();
    mdu_valid = 0; pipe_valid = 0; #1;
    chk("C_after_count", mdu_count, 3);
    chk("C_after_ready", mdu_ready, 1);
    chk("C_after_stall", pipe_stall, 0);
    chk("C_head_waddr", rf_waddr, 2);
    chk("C_head_wdata", rf_wdata, 64'h20);
    tick(); #1;
    chk("C_waddr3", rf_waddr, 3);
    chk("C_count2", mdu_count, 2);
    tick(); #1;
    chk("C_waddr4", rf_waddr, 4);
    tick(); #1;
    chk("C_waddr6", rf_waddr, 6);
    chk("C_wdata6", rf_wdata, 64'h23);
    chk("C_empty", mdu_count, 0);
    tick();

    // x0 handling
    pipe_valid = 1; pipe_rd_en = 1; pipe_rd = 1; pipe_result = 64'h31;
    mdu_valid = 1; mdu_rd = 8; mdu_result = 64'h88; #1;
    chk("D_count0", mdu_count, 0);
    tick();
    pipe_rd = 0; pipe_result = 64'h32;
    mdu_rd = 0; mdu_result = 64'hFF; #1;
    chk("D_ready", mdu_ready, 1);
    chk("D_count1", mdu_count, 1);
    chk("D_pipe_waddr", rf_waddr, 1);
    chk("D_pipe_wdata", rf_wdata, 64'h31);
    tick();
    mdu_valid = 0; #1;
    chk("D_count_after", mdu_count, 0);
    chk("D_we", rf_we, 1);
    chk("D_waddr", rf_waddr, 8);
    chk("D_wdata", rf_wdata, 64'h88);
    tick(); #1;
    chk("D_x0_no_we", rf_we, 0);
    chk("D_x0_count", mdu_count, 0);
    chk("D_x0_pending", mdu_pending, 0);
    pipe_valid = 0;

    // Simultaneous push and pop across pointer wrap
    tick();
    pipe_valid = 1; pipe_rd = 1; pipe_result = 64'h41;
    mdu_valid = 1; mdu_rd = 10; mdu_result = 64'hA0;
    tick();
    mdu_rd = 11; mdu_result = 64'hA1;
    tick();
    pipe_valid = 0;
    q = {10, 11};
    exp_rd = 0;
    for (int k = 0; k < 6; k++) begin
      mdu_rd = 5'(12 + k); mdu_result = 64'hB0 + 64'(k); #1;
      chk("E_count", mdu_count, 2);
      if (k > 0) chk("E_order", rf_waddr, 64'(exp_rd));
      exp_rd = q.pop_front();
      q.push_back(12 + k);
      tick();
    end
    mdu_valid = 0; #1;
    chk("E_order_last", rf_waddr, 64'(exp_rd));
    for (int j = 0; j < 2; j++) begin
      exp_rd = q.pop_front();
      tick(); #1;
      chk("E_drain_order", rf_waddr, 64'(exp_rd));
    end
    chk("E_empty", mdu_count, 0);

    // Reset mid-traffic
    pipe_valid = 1; pipe_rd = 1; pipe_result = 64'h51;
    for (int i = 0; i < 3; i++) begin
      mdu_valid = 1; mdu_rd = 5'(20 + i); mdu_result = 64'hC0 + 64'(i);
      tick();
    end
    mdu_valid = 0; #1;
    chk("F_count3", mdu_count, 3);
    chk("F_we_before", rf_we, 1);
    rst = 1'b0; #1;
    chk("F_rst_count", mdu_count, 0);
    chk("F_rst_we", rf_we, 0);
    chk("F_rst_pending", mdu_pending, 0);
    tick();
    rst = 1'b1; pipe_valid = 0; #1;
    chk("F_ready", mdu_ready, 1);
    chk("F_count_after", mdu_count, 0);
    tick(); #1;
    chk("F_we_after", rf_we, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
